pwm_fade_ctrl: RTL and testbench
================================

// Module: pwm_fade_ctrl
// PURPOSE
//  Sequencer for the RGB mixer's three pwm channels (R, G, B).
//  - Accepts a target colour over a valid/ready handshake.
//  - Ramps each channel's level one LSB at a time toward its target, at a programmable rate.
//  - Changes levels only on a PWM period boundary, so no pwm period ever sees a torn duty cycle.
//  - Sits between the control/input logic and the three pwm instances; drives their level inputs.
// PARAMETERS
//  WIDTH     8  level width; PWM period = 2**WIDTH clk; must match the pwm instances
//  RATE_DIV  4  PWM periods between ramp steps; legal range 1..255
// PORTS
//  clk         in   1        system clock, rising edge
//  reset_n     in   1        asynchronous, active-low reset
//  cmd_valid   in   1        target command present
//  cmd_ready   out  1        controller can accept a command
//  cmd_jump    in   1        1 = apply target at next boundary, no ramp
//  cmd_target  in   3*WIDTH  {R,G,B} target levels, R in MSBs
//  level_r     out  WIDTH    level to red pwm
//  level_g     out  WIDTH    level to green pwm
//  level_b     out  WIDTH    level to blue pwm
//  period_tick out  1        1-clk pulse, first clk of each PWM period
//  busy        out  1        ramp in progress
//  done        out  1        1-clk pulse, all levels reached target
// BEHAVIOUR
//  Reset (async assert, sync release): levels=0, targets=0, period_cnt=0, rate_cnt=0,
//   state=IDLE, cmd_ready=1, busy=0, done=0, period_tick=0.
//  period_cnt: free-running WIDTH-bit counter, wraps 2**WIDTH-1 -> 0.
//   period_tick=1 when period_cnt==0; registered and aligned with the pwm counters
//   (pwm instances are released from reset together with this block).
//  Handshake: command accepted on the clk where cmd_valid & cmd_ready.
//   cmd_ready=1 only in IDLE; cmd_valid while busy is held off, never dropped.
//   Acceptance latches cmd_target and cmd_jump and clears rate_cnt.
//  FSM:
//   IDLE -> RAMP on accept.
//   RAMP: on period_tick, rate_cnt increments. When rate_cnt reaches RATE_DIV-1 it clears,
//    and every channel with level!=target moves 1 LSB toward target (up or down).
//    Channels step independently and never overshoot.
//    Jump: all levels load their targets at the first period_tick after accept.
//    Exit RAMP -> DONE on the clk after all three levels equal their targets.
//   DONE: done=1 for exactly 1 clk, then -> IDLE.
//   Target equal to current levels: RAMP -> DONE at the first period_tick; no level change.
//  Level outputs change only on the clk following period_tick (registered); never mid-period.
//  Arithmetic: unsigned WIDTH bits, compare before step, so 0 and 2**WIDTH-1 never wrap.
//  busy=1 in RAMP and DONE; cmd_ready=~busy.
//  reset_n low mid-ramp: immediately forces reset values; the pending target is discarded.
//  Worst-case ramp duration: (2**WIDTH-1)*RATE_DIV periods.
// STRUCTURE
//  Shared package/header pwm_pkg:
//   - FSM encodings IDLE=2'd0, RAMP=2'd1, DONE=2'd2
//   - default WIDTH
//   - channel index constants CH_R/CH_G/CH_B
//  Sub-module fade_channel (x3): holds level and target for one channel.
//   - inputs: step_en, load_target, jump
//   - outputs: level, at_target
//  Top level holds period_cnt, rate_cnt, the FSM and the handshake.
// TESTING (run at WIDTH=4, RATE_DIV=2: period = 16 clk)
//  1. Reset release: levels=0, cmd_ready=1; period_tick every 16 clk, first one at period_cnt=0.
//  2. Target {R=3,G=0,B=1}, jump=0: R steps 0->1->2->3 and B steps 0->1, one step per 32 clk,
//     changes only after a tick; done pulses once; cmd_ready returns to 1.
//  3. From {15,15,15}, target {0,15,8}, jump=0: R decrements through 0 without wrap,
//     G stays 15, B stops at 8.
//  4. cmd_valid held high with a second target during a ramp: not accepted until IDLE,
//     then accepted in the first IDLE clk.
//  5. jump=1, target {9,4,12}: all levels land at the first tick after accept;
//     done pulses one clk later.
//  6. reset_n low mid-ramp at period_cnt=7: levels=0 and cmd_ready=1 asynchronously;
//     after release, ramping resumes only on a new command.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and FSM encoding for the RGB fade sequencer.
package pwm_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int RATE_DIV_DEF = 4;

    localparam int NUM_CH = 3;
    localparam int CH_R   = 0;
    localparam int CH_G   = 1;
    localparam int CH_B   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } fade_state_e;

endpackage

// File: rtl/fade_channel.sv
// One colour channel: holds target and current level, steps one LSB
// toward target on request or loads it outright on a jump.
module fade_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_en,
    input  logic             load_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] target_in,
    output logic [WIDTH-1:0] level,
    output logic             at_target
);

    logic [WIDTH-1:0] target;

    assign at_target = (level == target);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level  <= '0;
            target <= '0;
        end else begin
            if (load_target) begin
                target <= target_in;
            end
            // compare before step so the ends of the range never wrap
            if (jump) begin
                level <= target;
            end else if (step_en && !at_target) begin
                if (level < target) begin
                    level <= level + 1'b1;
                end else begin
                    level <= level - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// RGB fade sequencer: accepts a target colour and ramps the three pwm
// levels toward it, changing levels only on pwm period boundaries.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int RATE_DIV = RATE_DIV_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_jump,
    input  logic [3*WIDTH-1:0] cmd_target,
    output logic [WIDTH-1:0]   level_r,
    output logic [WIDTH-1:0]   level_g,
    output logic [WIDTH-1:0]   level_b,
    output logic               period_tick,
    output logic               busy,
    output logic               done
);

    localparam logic [WIDTH-1:0] PERIOD_LAST = '1;
    localparam logic [7:0]       RATE_LAST   = 8'(RATE_DIV - 1);

    fade_state_e      state;
    logic [WIDTH-1:0] period_cnt;
    logic [7:0]       rate_cnt;
    logic             jump_q;
    logic             seen_tick;
    logic             accept;
    logic             step_en;
    logic             jump_en;
    logic             all_at;
    logic [NUM_CH-1:0] at_tgt;
    logic [WIDTH-1:0] lvl [NUM_CH];

    assign accept  = cmd_valid && cmd_ready;
    assign all_at  = &at_tgt;
    assign step_en = (state == RAMP) && period_tick && !jump_q
                     && (rate_cnt == RATE_LAST);
    assign jump_en = (state == RAMP) && period_tick && jump_q;

    // tick is registered so it is high while period_cnt (and the pwm
    // counters) sit at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt  <= '0;
            period_tick <= 1'b0;
        end else begin
            period_cnt  <= period_cnt + 1'b1;
            period_tick <= (period_cnt == PERIOD_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rate_cnt  <= '0;
            jump_q    <= 1'b0;
            seen_tick <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RAMP;
                        jump_q    <= cmd_jump;
                        rate_cnt  <= '0;
                        seen_tick <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RAMP: begin
                    // completion is only judged once a boundary has passed
                    if (all_at && (period_tick || seen_tick)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (period_tick) begin
                        seen_tick <= 1'b1;
                        if (rate_cnt == RATE_LAST) begin
                            rate_cnt <= '0;
                        end else begin
                            rate_cnt <= rate_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fade_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .step_en    (step_en),
            .load_target(accept),
            .jump       (jump_en),
            .target_in  (cmd_target[(NUM_CH-1-i)*WIDTH +: WIDTH]),
            .level      (lvl[i]),
            .at_target  (at_tgt[i])
        );
    end

    assign level_r = lvl[CH_R];
    assign level_g = lvl[CH_G];
    assign level_b = lvl[CH_B];

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl at WIDTH=4, RATE_DIV=2 (16-clk period).
module tb_pwm_fade_ctrl;

    localparam int W   = 4;
    localparam int RD  = 2;
    localparam int PER = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_jump = 1'b0;
    logic [3*W-1:0] cmd_target = '0;
    logic          cmd_ready;
    logic [W-1:0]  level_r, level_g, level_b;
    logic          period_tick, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [11:0] tgt;
        logic        jump;
        logic [11:0] exp_lvl;
        int          exp_ticks;
    } vec_t;

    vec_t vecs [5];

    pwm_fade_ctrl #(.WIDTH(W), .RATE_DIV(RD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_jump   (cmd_jump),
        .cmd_target (cmd_target),
        .level_r    (level_r),
        .level_g    (level_g),
        .level_b    (level_b),
        .period_tick(period_tick),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] lv();
        return {level_r, level_g, level_b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // drive a command and return in the clk after it was accepted
    task automatic send(input logic [11:0] tgt, input logic j,
                        input bit hold);
        cmd_target = tgt;
        cmd_jump   = j;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                cyc();
                if (!hold) cmd_valid = 1'b0;
                return;
            end
            cyc();
        end
        chk("accept_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    // watch a ramp to completion; every level change must follow a
    // tick and (when ramping) move exactly one LSB toward target
    task automatic wait_done(input string name, input logic [11:0] tgt,
                             input logic j, input logic [11:0] exp_lvl,
                             input int exp_ticks);
        int          ticks;
        bit          got;
        bit          prev_tick;
        logic [11:0] prev, cur;
        logic [3:0]  o, n, t, e;
        ticks = 0;
        got = 0;
        prev_tick = 0;
        prev = lv();
        for (int c = 0; c < exp_ticks * PER + 64 && !got; c++) begin
            cur = lv();
            if (cur !== prev) begin
                chk({name, "_chg_after_tick"}, 32'(prev_tick), 1);
                if (!j) begin
                    for (int k = 0; k < 3; k++) begin
                        o = prev[k*4 +: 4];
                        n = cur[k*4 +: 4];
                        t = tgt[k*4 +: 4];
                        e = (o < t) ? o + 4'd1 : (o > t) ? o - 4'd1 : o;
                        chk({name, "_step"}, 32'(n), 32'(e));
                    end
                end
            end
            if (period_tick) ticks++;
            if (done) begin
                got = 1;
                chk({name, "_ticks"}, ticks, exp_ticks);
                chk({name, "_levels"}, 32'(cur), 32'(exp_lvl));
                chk({name, "_busy_in_done"}, 32'(busy), 1);
            end
            prev = cur;
            prev_tick = period_tick;
            if (!got) cyc();
        end
        if (!got) begin
            chk({name, "_done_timeout"}, 0, 1);
        end else begin
            cyc();
            chk({name, "_done_1clk"}, 32'(done), 0);
            chk({name, "_ready_back"}, 32'(cmd_ready), 1);
            chk({name, "_busy_off"}, 32'(busy), 0);
        end
    endtask

    initial begin
        int first_t, second_t, n_done;

        vecs[0] = '{12'h301, 1'b0, 12'h301, 6};
        vecs[1] = '{12'hFFF, 1'b1, 12'hFFF, 1};
        vecs[2] = '{12'h0F8, 1'b0, 12'h0F8, 30};
        vecs[3] = '{12'h0F8, 1'b0, 12'h0F8, 1};
        vecs[4] = '{12'h94C, 1'b1, 12'h94C, 1};

        // reset state and tick cadence
        repeat (3) @(posedge clk);
        #1;
        chk("rst_levels", 32'(lv()), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tick", 32'(period_tick), 0);
        @(negedge clk);
        reset_n = 1'b1;
        first_t = -1;
        second_t = -1;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (period_tick) begin
                if (first_t < 0) first_t = c;
                else if (second_t < 0) second_t = c;
            end
        end
        chk("tick_first", first_t, PER);
        chk("tick_second", second_t, 2 * PER);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].tgt, vecs[i].jump, 0);
            chk("busy_after_accept", 32'(busy), 1);
            wait_done($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].jump,
                      vecs[i].exp_lvl, vecs[i].exp_ticks);
        end

        // second command held during a ramp, taken in first IDLE clk
        send(12'hA4C, 1'b0, 1);
        cmd_target = 12'hA5C;
        chk("hold_ready_low", 32'(cmd_ready), 0);
        wait_done("hold1", 12'hA4C, 1'b0, 12'hA4C, 2);
        cyc();
        chk("hold_accepted", 32'(cmd_ready), 0);
        chk("hold_busy", 32'(busy), 1);
        cmd_valid = 1'b0;
        wait_done("hold2", 12'hA5C, 1'b0, 12'hA5C, 2);

        // async reset in the middle of a ramp, at period_cnt == 7
        send(12'h000, 1'b0, 0);
        for (int c = 0; c < 200 && lv() == 12'hA5C; c++) cyc();
        chk("mid_ramp_moved", 32'(lv()), 32'h94B);
        for (int c = 0; c < 40 && !period_tick; c++) cyc();
        repeat (7) cyc();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_levels", 32'(lv()), 0);
        chk("async_ready", 32'(cmd_ready), 1);
        chk("async_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 3 * PER * RD; c++) begin
            cyc();
            if (done || busy || lv() != 12'h000) n_done++;
        end
        chk("idle_after_reset", n_done, 0);
        send(12'h123, 1'b1, 0);
        wait_done("post_reset", 12'h123, 1'b1, 12'h123, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
